// File: rtl/phase_error_tdc_if.sv
// Control/result bundle between the phase TDC and its consumer (loop filter, lock detect).
// The consumer is the master: it owns enable and receives the error stream.
interface phase_error_tdc_if #(
    parameter int CNT_W = 8
);
    logic                  enable;
    logic signed [CNT_W:0] phase_err;
    logic                  err_valid;
    logic                  slip;
    logic                  sat;

    modport master (output enable, input  phase_err, err_valid, slip, sat);
    modport slave  (input  enable, output phase_err, err_valid, slip, sat);
endinterface

// File: rtl/phase_error_tdc.sv
// Time-to-digital phase detector: signed distance, in clk_sys cycles, between
// ref_in and fb_in rising edges, one error word per edge pair.

// Per-input synchronizer plus registered rising-edge detect.
module phase_error_tdc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;
    // vld_pipe marks when dly holds a real post-reset sample, so an input
    // that is already high when reset releases never looks like an edge.
    logic [SYNC_STAGES:0]   vld_pipe;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            dly      <= 1'b0;
            vld_pipe <= '0;
            rise     <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], din};
            dly      <= sync[SYNC_STAGES-1];
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            rise     <= sync[SYNC_STAGES-1] & ~dly & vld_pipe[SYNC_STAGES];
        end
    end
endmodule

module phase_error_tdc #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               ref_in,
    input  logic               fb_in,
    phase_error_tdc_if.slave   bus
);
    localparam int NUM_LANES = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

    logic [NUM_LANES-1:0] lane_in;
    logic [NUM_LANES-1:0] rise;

    // lane 0 = reference, lane 1 = feedback
    assign lane_in = {fb_in, ref_in};

    phase_error_tdc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_LANES-1:0] (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .din     (lane_in),
        .rise    (rise)
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic signed [CNT_W:0] err_q, err_d;
    logic                  vld_q, vld_d;
    logic                  slip_q, slip_d;
    logic                  sat_q, sat_d;
    logic signed [CNT_W:0] pos_err, neg_err;
    logic                  ref_rise, fb_rise, reopen;

    assign ref_rise = rise[0];
    assign fb_rise  = rise[1];
    assign pos_err  = $signed({1'b0, cnt_q});
    assign neg_err  = -pos_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        slip_d  = 1'b0;
        sat_d   = 1'b0;
        reopen  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: reopen = 1'b1;
                REF_LEAD: begin
                    if (cnt_q == CNT_MAX) begin
                        // timeout wins; any edge this cycle starts a fresh pair
                        vld_d  = 1'b1;
                        sat_d  = 1'b1;
                        err_d  = pos_err;
                        reopen = 1'b1;
                    end else if (fb_rise) begin
                        vld_d   = 1'b1;
                        err_d   = pos_err;
                        state_d = ref_rise ? REF_LEAD : IDLE;
                        cnt_d   = ref_rise ? CNT_ONE : '0;
                    end else if (ref_rise) begin
                        slip_d = 1'b1;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FB_LEAD: begin
                    if (cnt_q == CNT_MAX) begin
                        vld_d  = 1'b1;
                        sat_d  = 1'b1;
                        err_d  = neg_err;
                        reopen = 1'b1;
                    end else if (ref_rise) begin
                        vld_d   = 1'b1;
                        err_d   = neg_err;
                        state_d = fb_rise ? FB_LEAD : IDLE;
                        cnt_d   = fb_rise ? CNT_ONE : '0;
                    end else if (fb_rise) begin
                        slip_d = 1'b1;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (reopen) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (ref_rise && fb_rise) begin
                    // coincident edges measure zero, unless this cycle already reports a timeout
                    if (!vld_d) begin
                        vld_d = 1'b1;
                        err_d = '0;
                    end
                end else if (ref_rise) begin
                    state_d = REF_LEAD;
                    cnt_d   = CNT_ONE;
                end else if (fb_rise) begin
                    state_d = FB_LEAD;
                    cnt_d   = CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            vld_q   <= 1'b0;
            slip_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            slip_q  <= slip_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.phase_err = err_q;
    assign bus.err_valid = vld_q;
    assign bus.slip      = slip_q;
    assign bus.sat       = sat_q;
endmodule

// File: doc/phase_error_tdc.md
# phase_error_tdc

Time-to-digital phase detector that sits directly upstream of the lock detector in the DPLL loop. It samples the reference and feedback clocks with a fast system clock, measures the signed distance between their rising edges in system-clock cycles, and emits one phase-error word per reference/feedback edge pair. The loop filter and the lock logic consume this error word.

## Interface
- CNT_W, 8: magnitude counter width; phase_err is CNT_W+1 bits, signed two's complement.
- TIMEOUT, 255: maximum measurable edge separation in clk_sys cycles; legal range is 1 .. 2^CNT_W-1.
- SYNC_STAGES, 2: synchronizer depth on ref_in and fb_in; minimum 2.

- clk_sys, input, 1: system clock, the only clock; must run much faster than clk_ref and clk_fb.
- rst_n, input, 1: asynchronous active-low reset.
- ref_in, input, 1: reference clock, sampled as asynchronous data.
- fb_in, input, 1: feedback clock, sampled as asynchronous data.
- enable, input, 1: measurement enable.
- phase_err, output, CNT_W+1: signed error. Positive means ref leads fb; negative means fb leads ref.
- err_valid, output, 1: one-cycle strobe; phase_err is valid in that cycle.
- slip, output, 1: one-cycle strobe; the leading clock produced a second edge before the lagging clock produced one.
- sat, output, 1: one-cycle strobe; the measurement hit TIMEOUT.

## Operation
- Each of ref_in and fb_in passes through a SYNC_STAGES flop chain. Rising-edge detect compares the last sync stage with one further registered copy.
- The FSM has three states: IDLE, REF_LEAD and FB_LEAD. The magnitude counter is cnt, CNT_W bits.
- IDLE:
  - ref edge alone: go to REF_LEAD, cnt=1.
  - fb edge alone: go to FB_LEAD, cnt=1.
  - both edges in the same cycle: err_valid=1, phase_err=0, stay in IDLE.
- REF_LEAD:
  - fb edge: err_valid=1, phase_err=+cnt, go to IDLE.
  - fb edge and ref edge in the same cycle: emit +cnt, go to REF_LEAD with cnt=1.
  - ref edge only: slip=1, no err_valid, cnt=1, stay in REF_LEAD.
  - no edge: cnt increments.
  - cnt==TIMEOUT with no fb edge: err_valid=1, sat=1, phase_err=+TIMEOUT, go to IDLE.
- FB_LEAD: mirror image of REF_LEAD with ref and fb swapped and the sign negated.
- Emitted magnitudes therefore lie in 1..TIMEOUT. A magnitude of 0 is emitted only for coincident edges.
- cnt never wraps. Timeout takes priority over a closing edge detected in the same cycle: that cycle emits the saturated value, and the edge is then treated as an opening edge from IDLE.
- enable=0 forces IDLE and clears cnt. No strobes are produced, including in the cycle enable falls. Edges detected in the cycle enable rises are honoured.
- Reset, including mid-measurement, clears all registers. The synchronizer and edge-detect flops reset to 0, so a ref_in or fb_in that is already high after reset does not count as an edge.

## Timing
- Reset values: phase_err=0, err_valid=0, slip=0, sat=0, FSM=IDLE, cnt=0.
- All outputs are registered. phase_err holds its last value between strobes.
- Latency:
  - The closing input edge first sampled high at clk_sys edge k gives err_valid high in the cycle after edge k+SYNC_STAGES+1.
  - Both inputs see the same latency, so the measured difference is unaffected.
- Resolution is one clk_sys cycle. Synchronizer uncertainty is ±1 cycle per edge.
- err_valid, slip and sat are never high for more than one cycle per event. slip and err_valid are never high together.
- The block is always ready for a new measurement the cycle after err_valid. There is no backpressure.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n low with ref_in and fb_in high, release, hold the inputs static for 50 cycles.
  - Required: every output stays 0.
- Fixed lag:
  - Stimulus: ref and fb at period 40 clk_sys, fb delayed 5 cycles.
  - Required: one err_valid per period with phase_err=+5. With fb leading by 5 instead: phase_err=-5.
- Coincident edges:
  - Stimulus: identical ref and fb waveforms.
  - Required: phase_err=0 with err_valid once per period. slip and sat never assert.
- Slip:
  - Stimulus: ref period 20, fb disabled, TIMEOUT=255.
  - Required: slip every 20 cycles, no err_valid.
- Timeout:
  - Stimulus: TIMEOUT=30, a single ref edge, fb held low.
  - Required: err_valid and sat together with phase_err=+30, then the FSM returns to IDLE.
- Enable/reset mid-measurement:
  - Stimulus: enable dropped, or rst_n pulsed, 10 cycles after a ref edge; then fb edge; then resume normal traffic.
  - Required: no strobe for the interrupted pair. The next full pair measures correctly.
